// File: rtl/mem_bus_arbiter.sv
// Two-port arbiter sharing one single-port RAM between an instruction-fetch port
// and a data port. The data port wins by default; fetch is guaranteed service after STARVE_MAX data grants.
module mem_bus_arbiter #(
  parameter int AW         = 16,
  parameter int DW         = 32,
  parameter int STARVE_MAX = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_valid,
  output logic [DW-1:0] if_rdata,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic          dm_gnt,
  output logic          dm_valid,
  output logic [DW-1:0] dm_rdata,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_rw,
  input  logic [DW-1:0] mem_rdata
);

  // state  | meaning
  // IDLE   | no RAM access this cycle, bus driven to zero
  // IF_ACC | fetch read in progress, if_gnt high
  // DM_ACC | data load/store in progress, dm_gnt high
  typedef enum logic [1:0] {IDLE, IF_ACC, DM_ACC} state_t;

  localparam int CW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] SMAX = CW'(STARVE_MAX);

  state_t        state;
  logic [CW-1:0] starve_cnt;
  logic          pick_dm;
  logic          pick_if;

  always_comb begin
    pick_dm = dm_req && (!if_req || (starve_cnt < SMAX));
    pick_if = if_req && (!dm_req || (starve_cnt >= SMAX));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      starve_cnt <= '0;
      if_gnt     <= 1'b0;
      dm_gnt     <= 1'b0;
      if_valid   <= 1'b0;
      dm_valid   <= 1'b0;
      if_rdata   <= '0;
      dm_rdata   <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_rw     <= 1'b0;
    end else begin
      // Completion of the access that ends at this edge
      if_valid <= (state == IF_ACC);
      dm_valid <= (state == DM_ACC);
      if (state == IF_ACC)
        if_rdata <= mem_rdata;
      if ((state == DM_ACC) && !mem_rw)
        dm_rdata <= mem_rdata;

      if (pick_dm) begin
        state     <= DM_ACC;
        if_gnt    <= 1'b0;
        dm_gnt    <= 1'b1;
        mem_addr  <= dm_addr;
        mem_wdata <= dm_wdata;
        mem_rw    <= dm_we;
        if (!if_req)
          starve_cnt <= '0;
        else if (starve_cnt < SMAX)
          starve_cnt <= starve_cnt + 1'b1;
      end else if (pick_if) begin
        state      <= IF_ACC;
        if_gnt     <= 1'b1;
        dm_gnt     <= 1'b0;
        mem_addr   <= if_addr;
        mem_wdata  <= '0;
        mem_rw     <= 1'b0;
        starve_cnt <= '0;
      end else begin
        state     <= IDLE;
        if_gnt    <= 1'b0;
        dm_gnt    <= 1'b0;
        mem_addr  <= '0;
        mem_wdata <= '0;
        mem_rw    <= 1'b0;
        if (!if_req)
          starve_cnt <= '0;
      end
    end
  end

endmodule

// File: doc/mem_bus_arbiter.md
MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 SHALL have parameter AW, default 16, address width.
REQ-002 SHALL have parameter DW, default 32, data width.
REQ-003 SHALL have parameter STARVE_MAX, default 3, the maximum consecutive data-port grants while fetch waits.
REQ-004 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-005 SHALL have port rst  input  1  reset; asynchronous, active-low.
REQ-006 SHALL have port if_req  input  1  fetch-port request, held until granted.
REQ-007 SHALL have port if_addr  input  AW  fetch address, stable while if_req=1.
REQ-008 SHALL have port if_gnt  output  1  fetch-port grant pulse, one cycle.
REQ-009 SHALL have port if_valid  output  1  fetch read-data valid pulse.
REQ-010 SHALL have port if_rdata  output  DW  fetch read data.
REQ-011 SHALL have port dm_req  input  1  data-port request, held until granted.
REQ-012 SHALL have port dm_we  input  1  data-port write enable (1=store, 0=load).
REQ-013 SHALL have port dm_addr  input  AW  data address.
REQ-014 SHALL have port dm_wdata  input  DW  store data.
REQ-015 SHALL have port dm_gnt  output  1  data-port grant pulse, one cycle.
REQ-016 SHALL have port dm_valid  output  1  data-port completion pulse (loads and stores).
REQ-017 SHALL have port dm_rdata  output  DW  load data.
REQ-018 SHALL have port mem_addr  output  AW  single-port RAM address.
REQ-019 SHALL have port mem_wdata  output  DW  RAM write data.
REQ-020 SHALL have port mem_rw  output  1  RAM direction, 1=write, 0=read.
REQ-021 SHALL have port mem_rdata  input  DW  RAM combinational read data.

Function
REQ-022 SHALL implement FSM states IDLE, IF_ACC, DM_ACC; one RAM access per ACC cycle.
REQ-023 SHALL, in IDLE or any ACC state, pick the next state at each edge: DM_ACC if dm_req and (not if_req or starve_cnt<STARVE_MAX); IF_ACC if if_req and (not dm_req or starve_cnt>=STARVE_MAX); else IDLE.
REQ-024 SHALL assert if_gnt=1 exactly while state=IF_ACC, dm_gnt=1 exactly while state=DM_ACC; never both.
REQ-025 SHALL drive mem_addr=if_addr, mem_rw=0 in IF_ACC; mem_addr=dm_addr, mem_wdata=dm_wdata, mem_rw=dm_we in DM_ACC; mem_addr=0, mem_wdata=0, mem_rw=0 in IDLE.
REQ-026 SHALL capture mem_rdata at the end of an ACC read cycle into if_rdata/dm_rdata and pulse the matching valid for exactly the next cycle; latency req(IDLE)->gnt 1 cycle, gnt->valid 1 cycle.
REQ-027 SHALL leave dm_rdata unchanged on a store; dm_valid still pulses.
REQ-028 SHALL hold if_rdata/dm_rdata stable between captures.
REQ-029 SHALL treat a req still high after its gnt cycle as a new request; back-to-back grants to one port allowed.
REQ-030 SHALL keep a starve_cnt (width ceil(log2(STARVE_MAX+1))): +1 on each DM_ACC entry while if_req=1, saturating at STARVE_MAX; cleared on IF_ACC entry or when if_req=0.
REQ-031 SHALL, with both requests high continuously and STARVE_MAX=3, produce grant order DM,DM,DM,IF,DM,DM,DM,IF...
REQ-032 SHALL ignore address/data changes of a non-granted port.

Reset
REQ-033 SHALL on rst=0, immediately and regardless of clk: state=IDLE, starve_cnt=0, if_gnt=dm_gnt=0, if_valid=dm_valid=0, if_rdata=dm_rdata=0, mem_addr=0, mem_wdata=0, mem_rw=0.
REQ-034 SHALL, on reset mid-access, abort it with no valid pulse and no mem_rw=1 after rst falls.
REQ-035 SHALL leave IDLE no earlier than the first rising edge after rst rises.

Verification
REQ-036 SHALL test: if_req=1, if_addr=0x0005, mem_rdata=0xE1A00000 -> if_gnt cycle 1, if_valid=1 and if_rdata=0xE1A00000 cycle 2.
REQ-037 SHALL test: dm_req=1, dm_we=1, dm_addr=0x0010, dm_wdata=0xDEADBEEF -> one cycle mem_rw=1, mem_addr=0x0010; dm_valid next cycle; dm_rdata unchanged.
REQ-038 SHALL test: if_req and dm_req rise same cycle, starve_cnt=0 -> dm_gnt first, if_gnt next cycle.
REQ-039 SHALL test: both reqs held 10 cycles -> grant sequence DM,DM,DM,IF,DM,DM,DM,IF,DM,DM; never both gnts high.
REQ-040 SHALL test: rst=0 asserted mid DM_ACC store -> mem_rw=0, dm_gnt=0 immediately; no dm_valid; all outputs zero.
REQ-041 SHALL test: no requests for 5 cycles -> state IDLE, mem_addr=0, mem_rw=0, all gnts/valids 0.
